id_ex_pipe_reg: RTL and testbench

//  ID->EX pipeline register of the 5-stage MIPS core; sits directly downstream of CONTROL_UNIT and register file.

---
 rtl/mips_pkg.sv | 24 ++
 rtl/pipe_reg_en_clr.sv | 19 +
 rtl/id_ex_pipe_reg.sv | 94 +++++++++
 tb/tb_id_ex_pipe_reg.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, ALU encodings and the decode control bundle
package mips_pkg;
  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int ALUC_W = 3;
  localparam logic [ALUC_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALUC_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALUC_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALUC_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALUC_W-1:0] ALU_SLT = 3'b111;
  typedef struct packed {
    logic              RegWrite;
    logic              MemtoReg;
    logic              MemWrite;
    logic [ALUC_W-1:0] ALUControl;
    logic              ALUSrc;
    logic              RegDst;
    logic              Load;
  } ctrl_bundle_t;
  // an edge inserts a bubble when flushed, or when a non-instruction is loaded
  function automatic logic is_bubble(input logic flush, input logic stall, input logic valid);
    return flush | (~stall & ~valid);
  endfunction
endpackage

// File: rtl/pipe_reg_en_clr.sv
// pipe_reg_en_clr: W-bit register with async reset, enable and sync clear (clear wins)
module pipe_reg_en_clr #(
  parameter int W = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_q;
  // clear loads zeros even while the enable is low
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) r_q <= '0;
    else if (i_clr) r_q <= '0;
    else if (i_en) r_q <= i_d;
  assign o_q = r_q;
endmodule

// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: ID->EX pipeline register with stall, flush and bubble counter
module id_ex_pipe_reg
  import mips_pkg::*;
#(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int REG_AW = mips_pkg::REG_AW,
  parameter int ALUC_W = mips_pkg::ALUC_W,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_StallE,
  input  logic              i_FlushE,
  input  logic              i_ValidD,
  input  logic              i_RegWriteD,
  input  logic              i_MemtoRegD,
  input  logic              i_MemWriteD,
  input  logic [ALUC_W-1:0] i_ALUControlD,
  input  logic              i_ALUSrcD,
  input  logic              i_RegDstD,
  input  logic              i_LoadD,
  input  logic [DATA_W-1:0] i_RD1D,
  input  logic [DATA_W-1:0] i_RD2D,
  input  logic [REG_AW-1:0] i_RsD,
  input  logic [REG_AW-1:0] i_RtD,
  input  logic [REG_AW-1:0] i_RdD,
  input  logic [DATA_W-1:0] i_SignImmD,
  output logic              o_ValidE,
  output logic              o_RegWriteE,
  output logic              o_MemtoRegE,
  output logic              o_MemWriteE,
  output logic [ALUC_W-1:0] o_ALUControlE,
  output logic              o_ALUSrcE,
  output logic              o_RegDstE,
  output logic              o_LoadE,
  output logic [DATA_W-1:0] o_RD1E,
  output logic [DATA_W-1:0] o_RD2E,
  output logic [REG_AW-1:0] o_RsE,
  output logic [REG_AW-1:0] o_RtE,
  output logic [REG_AW-1:0] o_RdE,
  output logic [DATA_W-1:0] o_SignImmE,
  output logic [CNT_W-1:0]  o_BubbleCnt
);
  localparam int CW = $bits(ctrl_bundle_t) + 1;
  localparam int DW = 3 * DATA_W + 3 * REG_AW;
  ctrl_bundle_t        w_ctrl_d, w_ctrl_q;
  logic                w_valid_q;
  logic [DW-1:0]       w_data_d, w_data_q;
  logic                w_bubble;
  logic [CNT_W-1:0]    r_bubble_cnt;
  // side-effecting controls are gated off when decode holds no real instruction
  always_comb begin
    w_ctrl_d            = '0;
    w_ctrl_d.RegWrite   = i_RegWriteD & i_ValidD;
    w_ctrl_d.MemtoReg   = i_MemtoRegD;
    w_ctrl_d.MemWrite   = i_MemWriteD & i_ValidD;
    w_ctrl_d.ALUControl = i_ALUControlD;
    w_ctrl_d.ALUSrc     = i_ALUSrcD;
    w_ctrl_d.RegDst     = i_RegDstD;
    w_ctrl_d.Load       = i_LoadD & i_ValidD;
  end
  assign w_data_d = {i_RD1D, i_RD2D, i_RsD, i_RtD, i_RdD, i_SignImmD};
  pipe_reg_en_clr #(.W(CW)) u_ctrl (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (~i_StallE),
    .i_clr (i_FlushE),
    .i_d   ({i_ValidD, w_ctrl_d}),
    .o_q   ({w_valid_q, w_ctrl_q})
  );
  pipe_reg_en_clr #(.W(DW)) u_data (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (~i_StallE),
    .i_clr (i_FlushE),
    .i_d   (w_data_d),
    .o_q   (w_data_q)
  );
  assign w_bubble = is_bubble(i_FlushE, i_StallE, i_ValidD);
  // saturating bubble counter, frozen at all-ones
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) r_bubble_cnt <= '0;
    else if (w_bubble && r_bubble_cnt != {CNT_W{1'b1}}) r_bubble_cnt <= r_bubble_cnt + 1'b1;
  assign o_ValidE      = w_valid_q;
  assign o_RegWriteE   = w_ctrl_q.RegWrite;
  assign o_MemtoRegE   = w_ctrl_q.MemtoReg;
  assign o_MemWriteE   = w_ctrl_q.MemWrite;
  assign o_ALUControlE = w_ctrl_q.ALUControl;
  assign o_ALUSrcE     = w_ctrl_q.ALUSrc;
  assign o_RegDstE     = w_ctrl_q.RegDst;
  assign o_LoadE       = w_ctrl_q.Load;
  assign {o_RD1E, o_RD2E, o_RsE, o_RtE, o_RdE, o_SignImmE} = w_data_q;
  assign o_BubbleCnt   = r_bubble_cnt;
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb_id_ex_pipe_reg: randomized scoreboard bench for the ID->EX pipeline register
module tb_id_ex_pipe_reg;
  import mips_pkg::*;
  logic clk = 0, rst = 0;
  always #5 clk = ~clk;
  logic stall = 0, flush = 0, v = 0, rw = 0, m2r = 0, mw = 0, asrc = 0, rdst = 0, ld = 0;
  logic [2:0]  aluc = 0;
  logic [31:0] rd1 = 0, rd2 = 0, imm = 0;
  logic [4:0]  rs = 0, rt = 0, rd = 0;
  logic        o_v, o_rw, o_m2r, o_mw, o_asrc, o_rdst, o_ld;
  logic [2:0]  o_aluc;
  logic [31:0] o_rd1, o_rd2, o_imm;
  logic [4:0]  o_rs, o_rt, o_rd;
  logic [15:0] o_cnt;
  logic        s_v, s_rw, s_m2r, s_mw, s_asrc, s_rdst, s_ld;
  logic [2:0]  s_aluc;
  logic [31:0] s_rd1, s_rd2, s_imm;
  logic [4:0]  s_rs, s_rt, s_rd;
  logic [1:0]  s_cnt;
  id_ex_pipe_reg dut (
    .i_clk(clk), .i_rst(rst), .i_StallE(stall), .i_FlushE(flush), .i_ValidD(v),
    .i_RegWriteD(rw), .i_MemtoRegD(m2r), .i_MemWriteD(mw), .i_ALUControlD(aluc),
    .i_ALUSrcD(asrc), .i_RegDstD(rdst), .i_LoadD(ld), .i_RD1D(rd1), .i_RD2D(rd2),
    .i_RsD(rs), .i_RtD(rt), .i_RdD(rd), .i_SignImmD(imm),
    .o_ValidE(o_v), .o_RegWriteE(o_rw), .o_MemtoRegE(o_m2r), .o_MemWriteE(o_mw),
    .o_ALUControlE(o_aluc), .o_ALUSrcE(o_asrc), .o_RegDstE(o_rdst), .o_LoadE(o_ld),
    .o_RD1E(o_rd1), .o_RD2E(o_rd2), .o_RsE(o_rs), .o_RtE(o_rt), .o_RdE(o_rd),
    .o_SignImmE(o_imm), .o_BubbleCnt(o_cnt)
  );
  id_ex_pipe_reg #(.CNT_W(2)) dut_small (
    .i_clk(clk), .i_rst(rst), .i_StallE(stall), .i_FlushE(flush), .i_ValidD(v),
    .i_RegWriteD(rw), .i_MemtoRegD(m2r), .i_MemWriteD(mw), .i_ALUControlD(aluc),
    .i_ALUSrcD(asrc), .i_RegDstD(rdst), .i_LoadD(ld), .i_RD1D(rd1), .i_RD2D(rd2),
    .i_RsD(rs), .i_RtD(rt), .i_RdD(rd), .i_SignImmD(imm),
    .o_ValidE(s_v), .o_RegWriteE(s_rw), .o_MemtoRegE(s_m2r), .o_MemWriteE(s_mw),
    .o_ALUControlE(s_aluc), .o_ALUSrcE(s_asrc), .o_RegDstE(s_rdst), .o_LoadE(s_ld),
    .o_RD1E(s_rd1), .o_RD2E(s_rd2), .o_RsE(s_rs), .o_RtE(s_rt), .o_RdE(s_rd),
    .o_SignImmE(s_imm), .o_BubbleCnt(s_cnt)
  );
  typedef struct packed {
    logic v, rw, m2r, mw;
    logic [2:0] aluc;
    logic asrc, rdst, ld;
    logic [31:0] rd1, rd2;
    logic [4:0] rs, rt, rd;
    logic [31:0] imm;
    logic [15:0] cnt;
    logic [1:0] cnt2;
  } st_t;
  st_t m, q[$];
  int tests = 0, fails = 0;
  int max_cnt = 65535, max_cnt2 = 3;
  function automatic st_t actual();
    return '{o_v, o_rw, o_m2r, o_mw, o_aluc, o_asrc, o_rdst, o_ld,
             o_rd1, o_rd2, o_rs, o_rt, o_rd, o_imm, o_cnt, s_cnt};
  endfunction
  task automatic chk(input string name, input st_t a, input st_t e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, a, e);
    end
  endtask
  task automatic ceq(input string name, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, a, e);
    end
  endtask
  // reference model: what EX should hold after the coming edge
  function automatic void step();
    int c, c2;
    c = m.cnt;
    c2 = m.cnt2;
    if (flush || (!stall && !v)) begin
      c = (c == max_cnt) ? c : c + 1;
      c2 = (c2 == max_cnt2) ? c2 : c2 + 1;
    end
    if (flush) m = '0;
    else if (!stall) begin
      m.v = v; m.rw = rw && v; m.m2r = m2r; m.mw = mw && v; m.aluc = aluc;
      m.asrc = asrc; m.rdst = rdst; m.ld = ld && v;
      m.rd1 = rd1; m.rd2 = rd2; m.rs = rs; m.rt = rt; m.rd = rd; m.imm = imm;
    end
    m.cnt = c[15:0];
    m.cnt2 = c2[1:0];
  endfunction
  task automatic cyc();
    step();
    @(posedge clk);
    q.push_back(m);
    #1;
  endtask
  task automatic settle();
    @(negedge clk);
    #1;
  endtask
  task automatic rand_d();
    v = ($urandom_range(0, 3) != 0); rw = 1'($urandom); m2r = 1'($urandom); mw = 1'($urandom);
    aluc = 3'($urandom); asrc = 1'($urandom); rdst = 1'($urandom); ld = 1'($urandom);
    rd1 = $urandom; rd2 = $urandom; imm = $urandom;
    rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
  endtask
  task automatic do_reset();
    settle();
    rst = 1;
    #1;
    chk("async_reset", actual(), '0);
    m = '0;
    @(posedge clk);
    #1;
    rst = 0;
  endtask
  // monitor: compare DUT against the oldest expected entry away from the active edge
  always @(negedge clk)
    if (q.size() > 0) chk("pipe", actual(), q.pop_front());
  int sat_exp[5] = '{1, 2, 3, 3, 3};
  logic [15:0] saved;
  initial begin
    #2 rst = 1;
    #1 chk("reset_init", actual(), '0);
    m = '0;
    @(posedge clk);
    #1 rst = 0;
    v = 1; rd1 = 32'h5; rd2 = 32'h7; aluc = ALU_ADD; rw = 1;
    cyc();
    settle();
    ceq("add_rd1", o_rd1, 32'h5);
    ceq("add_rd2", o_rd2, 32'h7);
    ceq("add_aluc", {29'd0, o_aluc}, {29'd0, ALU_ADD});
    ceq("add_valid", {31'd0, o_v}, 1);
    ceq("add_rw", {31'd0, o_rw}, 1);
    saved = o_cnt;
    stall = 1;
    repeat (3) begin
      rand_d();
      cyc();
    end
    settle();
    ceq("stall_rd1", o_rd1, 32'h5);
    ceq("stall_valid", {31'd0, o_v}, 1);
    ceq("stall_cnt", {16'd0, o_cnt}, {16'd0, saved});
    stall = 0; flush = 1; v = 1; ld = 1; rw = 1;
    cyc();
    settle();
    ceq("flush_rw", {31'd0, o_rw}, 0);
    ceq("flush_ld", {31'd0, o_ld}, 0);
    ceq("flush_valid", {31'd0, o_v}, 0);
    ceq("flush_cnt", {16'd0, o_cnt}, {16'd0, saved} + 1);
    stall = 1;
    cyc();
    settle();
    ceq("flush_stall_valid", {31'd0, o_v}, 0);
    ceq("flush_stall_cnt", {16'd0, o_cnt}, {16'd0, saved} + 2);
    stall = 0; flush = 0; v = 1;
    cyc();
    stall = 1; flush = 1;
    do_reset();
    stall = 0; flush = 0; rand_d(); v = 1;
    cyc();
    flush = 1;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cyc();
      settle();
      ceq("sat_cnt2", {30'd0, s_cnt}, sat_exp[i]);
    end
    flush = 0;
    for (int i = 0; i < 400; i++) begin
      rand_d();
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      cyc();
      if (i == 200) begin
        stall = 1;
        do_reset();
      end
    end
    settle();
    settle();
    ceq("queue_drain", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
